// File: rtl/mul_div_unit_pkg.sv
// Shared MDU opcodes and FSM state type for the E-stage multiply/divide unit.
// The E-stage decoder and the stall unit use the same opcode values.
package mul_div_unit_pkg;

  localparam logic [3:0] MDU_NONE  = 4'h0;
  localparam logic [3:0] MDU_MULT  = 4'h1;
  localparam logic [3:0] MDU_MULTU = 4'h2;
  localparam logic [3:0] MDU_DIV   = 4'h3;
  localparam logic [3:0] MDU_DIVU  = 4'h4;
  localparam logic [3:0] MDU_MFHI  = 4'h5;
  localparam logic [3:0] MDU_MFLO  = 4'h6;
  localparam logic [3:0] MDU_MTHI  = 4'h7;
  localparam logic [3:0] MDU_MTLO  = 4'h8;

  typedef enum logic [0:0] {StIdle, StRun} mdu_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_arith.sv
// Combinational datapath of the MDU: 32x32->64 multiply and 32/32 divide,
// signed or unsigned, plus the divide-by-zero hold flag.
module mdu_arith
  import mul_div_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n,
  output logic        div_hold
);

  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [63:0] prod;

  // Work on magnitudes so -2^31 / -1 and friends wrap like the reference ISA.
  always_comb begin
    signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    a_neg     = signed_op & rs_data[31];
    b_neg     = signed_op & rt_data[31];
    a_mag     = a_neg ? -rs_data : rs_data;
    b_mag     = b_neg ? -rt_data : rt_data;
    prod      = {32'd0, a_mag} * {32'd0, b_mag};
    if (a_neg ^ b_neg) begin
      prod = -prod;
    end
    div_hold  = is_div_op(op) && (rt_data == 32'd0);
    b_safe    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    hi_n      = 32'd0;
    lo_n      = 32'd0;
    if (is_mul_op(op)) begin
      hi_n = prod[63:32];
      lo_n = prod[31:0];
    end else if (is_div_op(op)) begin
      lo_n = (a_neg ^ b_neg) ? -q_mag : q_mag;
      hi_n = a_neg ? -r_mag : r_mag;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT*/DIV* over a fixed latency,
// MTHI/MTLO in one cycle, MFHI/MFLO served combinationally.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cancel,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] read_data
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_hold_q, pend_hold_d;

  logic [31:0] hi_n, lo_n;
  logic        div_hold;
  logic        go;

  mdu_arith u_arith (
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .hi_n     (hi_n),
    .lo_n     (lo_n),
    .div_hold (div_hold)
  );

  assign busy = (state_q == StRun);
  assign go   = start & ~cancel & ~busy;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_hold_d = pend_hold_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          if (is_mul_op(op) || is_div_op(op)) begin
            state_d     = StRun;
            cnt_d       = is_mul_op(op) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
            pend_hi_d   = hi_n;
            pend_lo_d   = lo_n;
            pend_hold_d = div_hold;
          end else if (op == MDU_MTHI) begin
            hi_d = rs_data;
          end else if (op == MDU_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (!pend_hold_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_hold_q <= pend_hold_d;
    end
  end

  always_comb begin
    read_data = 32'd0;
    if (op == MDU_MFHI) begin
      read_data = hi_q;
    end else if (op == MDU_MFLO) begin
      read_data = lo_q;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && start && !cancel && busy) begin
      $display("mul_div_unit: start while busy ignored (op=%0h)", op);
    end
  end
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a queue scoreboard of expected HI/LO results.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cancel;
  logic [3:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] read_data;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mul_div_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cancel    (cancel),
    .op        (op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .busy      (busy),
    .read_data (read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model, independent of the RTL datapath: native 64-bit / int arithmetic.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sp;
    int     sa, sb;
    sa = a;
    sb = b;
    case (o)
      MDU_MULT:  begin sp = longint'(sa) * longint'(sb); return sp; end
      MDU_MULTU: return {32'd0, a} * {32'd0, b};
      MDU_DIV:   if (b == 0) return {hi_m, lo_m};
                 else return {32'(sa % sb), 32'(sa / sb)};
      MDU_DIVU:  if (b == 0) return {hi_m, lo_m};
                 else return {a % b, a / b};
      default:   return {hi_m, lo_m};
    endcase
  endfunction

  task automatic read_hilo(input string tag);
    op = MDU_MFHI;
    #1 check({tag, "_hi"}, read_data, hi_m);
    op = MDU_MFLO;
    #1 check({tag, "_lo"}, read_data, lo_m);
    op = MDU_NONE;
  endtask

  // Issue a multi-cycle op, count busy cycles, then commit the scoreboard entry.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    int cnt;
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    sb_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busycyc"}, 32'(cnt), 32'(n));
    e = sb_q.pop_front();
    hi_m = e[63:32];
    lo_m = e[31:0];
    read_hilo(tag);
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a;
    if (o == MDU_MTHI) hi_m = a; else lo_m = a;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = MDU_NONE;
    rs_data = '0; rt_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    read_hilo("rst");

    run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5);
    check("mult_hi_const", hi_m, 32'hFFFF_FFFF);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 5);
    run_op("div", MDU_DIV, -32'sd7, 32'd2, 10);
    run_op("divu", MDU_DIVU, 32'd7, 32'd2, 10);
    run_op("mult_big", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 5);
    run_op("div_neg", MDU_DIV, 32'd100, -32'sd7, 10);

    mt(MDU_MTHI, 32'h1234);
    mt(MDU_MTLO, 32'h5678);
    check("mt_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    check("mt_busy1", 32'(busy), 32'd0);
    read_hilo("mt");

    mt(MDU_MTHI, 32'hAA);
    mt(MDU_MTLO, 32'hAA);
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    run_op("div0", MDU_DIV, 32'd5, 32'd0, 10);

    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = MDU_MULT; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = MDU_NONE;
    check("cancel_busy", 32'(busy), 32'd0);
    read_hilo("cancel");

    @(negedge clk);
    start = 1'b1; op = 4'hF; rs_data = 32'hDEAD; rt_data = 32'hBEEF;
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    check("unk_busy", 32'(busy), 32'd0);
    read_hilo("unk");

    // Reset during a multiply: nothing may commit afterwards.
    @(negedge clk);
    start = 1'b1; op = MDU_MULT; rs_data = 32'd6; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    repeat (2) @(negedge clk);
    check("rstmid_busy3", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    check("rstmid_busy", 32'(busy), 32'd0);
    read_hilo("rstmid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rstmid_late_busy", 32'(busy), 32'd0);
    end
    read_hilo("rstmid_late");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
